// File: rtl/alu_ctl_issue_if.sv
// Handshake bundle between fetch (IF/ID) and the ALUctl issue stage.
// master: issue-stage view (consumes instructions, produces decoded entries).
// slave:  the view of whatever drives instructions in and takes entries out.
interface alu_ctl_issue_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [6:0]      out_alu_ctl;
    logic            out_illegal;

    modport master (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instr, out_alu_ctl, out_illegal
    );

    modport slave (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instr, out_alu_ctl, out_illegal
    );
endinterface

// File: rtl/alu_ctl_issue.sv
// ALUctl issue stage: decodes an RV32I instruction into the 7-bit ALUctl
// (branch condition in [6:4], ALU op in [3:0]) and issues it through a
// registered valid/ready stage backed by a main + skid entry pair.
// Optional feature: define SAIL_ALUCTL_ILLEGAL_DETECT_EN to flag undecodable
// instructions on out_illegal (with ALUctl forced to 0); otherwise they decode
// as a plain ADD and out_illegal is tied low.
module alu_ctl_issue #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    alu_ctl_issue_if.master bus
);

    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOr    = 4'b0001;
    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSrl   = 4'b0011;
    localparam logic [3:0] AluSll   = 4'b0100;
    localparam logic [3:0] AluSra   = 4'b0101;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluSlt   = 4'b0111;
    localparam logic [3:0] AluXor   = 4'b1000;
    localparam logic [3:0] AluCsrrw = 4'b1001;
    localparam logic [3:0] AluCsrrs = 4'b1010;
    localparam logic [3:0] AluCsrrc = 4'b1011;

    localparam logic [2:0] BrNone = 3'b000;
    localparam logic [2:0] BrBeq  = 3'b001;
    localparam logic [2:0] BrBne  = 3'b010;
    localparam logic [2:0] BrBlt  = 3'b011;
    localparam logic [2:0] BrBge  = 3'b100;
    localparam logic [2:0] BrBltu = 3'b101;
    localparam logic [2:0] BrBgeu = 3'b110;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic [2:0] dec_br;
    logic [3:0] dec_alu;
    logic [6:0] dec_ctl;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
    logic       dec_ill;
`endif

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign alt    = bus.in_instr[30];

    // Combinational decode of the offered instruction; undecodable words fall
    // through as 000/ADD unless detection is enabled.
    always_comb begin
        dec_br  = BrNone;
        dec_alu = AluAdd;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
        dec_ill = 1'b0;
`endif
        case (opcode)
            OpLui: dec_alu = AluAnd;
            OpAuipc, OpJal, OpJalr, OpLoad, OpStore, OpFence: dec_alu = AluAdd;
            OpBranch: begin
                dec_alu = AluSub;
                case (funct3)
                    3'b000:  dec_br = BrBeq;
                    3'b001:  dec_br = BrBne;
                    3'b100:  dec_br = BrBlt;
                    3'b101:  dec_br = BrBge;
                    3'b110:  dec_br = BrBltu;
                    3'b111:  dec_br = BrBgeu;
                    default: begin
                        dec_alu = AluAdd;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
                        dec_ill = 1'b1;
`endif
                    end
                endcase
            end
            OpImm, OpReg: begin
                case (funct3)
                    3'b000:         dec_alu = (opcode == OpReg && alt) ? AluSub : AluAdd;
                    3'b001:         dec_alu = AluSll;
                    3'b010, 3'b011: dec_alu = AluSlt;
                    3'b100:         dec_alu = AluXor;
                    3'b101:         dec_alu = alt ? AluSra : AluSrl;
                    3'b110:         dec_alu = AluOr;
                    default:        dec_alu = AluAnd;
                endcase
            end
            OpSystem: begin
                case (funct3)
                    3'b000:         dec_alu = AluAdd;
                    3'b001, 3'b101: dec_alu = AluCsrrw;
                    3'b010, 3'b110: dec_alu = AluCsrrs;
                    3'b011, 3'b111: dec_alu = AluCsrrc;
                    default: begin
                        dec_alu = AluAdd;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
                        dec_ill = 1'b1;
`endif
                    end
                endcase
            end
            default: begin
                dec_alu = AluAdd;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
                dec_ill = 1'b1;
`endif
            end
        endcase
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
        dec_ctl = dec_ill ? 7'd0 : {dec_br, dec_alu};
`else
        dec_ctl = {dec_br, dec_alu};
`endif
    end

    logic            main_valid_q, main_valid_d;
    logic [XLEN-1:0] main_instr_q, main_instr_d;
    logic [6:0]      main_ctl_q,   main_ctl_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [6:0]      skid_ctl_q,   skid_ctl_d;
    logic            in_ready_q,   in_ready_d;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
    logic            main_ill_q,   main_ill_d;
    logic            skid_ill_q,   skid_ill_d;
`endif
    logic            accept;
    logic            drain;

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = main_valid_q & bus.out_ready;

    // Buffer next state. Skid only fills when main is stuck; since in_ready
    // mirrors "skid empty", an accept never coincides with a full skid.
    always_comb begin
        main_valid_d = main_valid_q;
        main_instr_d = main_instr_q;
        main_ctl_d   = main_ctl_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_ctl_d   = skid_ctl_q;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
        main_ill_d   = main_ill_q;
        skid_ill_d   = skid_ill_q;
`endif
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_instr_d = skid_instr_q;
                main_ctl_d   = skid_ctl_q;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
                main_ill_d   = skid_ill_q;
`endif
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_instr_d = bus.in_instr;
                main_ctl_d   = dec_ctl;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
                main_ill_d   = dec_ill;
`endif
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_instr_d = bus.in_instr;
            skid_ctl_d   = dec_ctl;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
            skid_ill_d   = dec_ill;
`endif
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_instr_q <= '0;
            main_ctl_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_ctl_q   <= '0;
            in_ready_q   <= 1'b0;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
            main_ill_q   <= 1'b0;
            skid_ill_q   <= 1'b0;
`endif
        end else begin
            main_valid_q <= main_valid_d;
            main_instr_q <= main_instr_d;
            main_ctl_q   <= main_ctl_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_ctl_q   <= skid_ctl_d;
            in_ready_q   <= in_ready_d;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
            main_ill_q   <= main_ill_d;
            skid_ill_q   <= skid_ill_d;
`endif
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_instr   = main_instr_q;
    assign bus.out_alu_ctl = main_ctl_q;
`ifdef SAIL_ALUCTL_ILLEGAL_DETECT_EN
    assign bus.out_illegal = main_ill_q;
`else
    assign bus.out_illegal = 1'b0;
`endif

endmodule
